// File: rtl/if_unit_if.sv
// Fetch-unit bus: pipeline controls, redirect targets, loader port and fetch results.
interface if_unit_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              enable;
    logic              PC_write;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_address;
    logic              jump_taken;
    logic [ADDR_W-1:0] jump_address;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [ADDR_W-1:0] PC_current;
    logic [DATA_W-1:0] instruc;
    logic [ADDR_W-1:0] PC_fetched;
    logic [ADDR_W-1:0] PC_plus_1;
    logic              valid;

    modport master (
        output enable, PC_write, branch_taken, branch_address,
        output jump_taken, jump_address, prog_we, prog_addr, prog_data,
        input  PC_current, instruc, PC_fetched, PC_plus_1, valid
    );

    modport slave (
        input  enable, PC_write, branch_taken, branch_address,
        input  jump_taken, jump_address, prog_we, prog_addr, prog_data,
        output PC_current, instruc, PC_fetched, PC_plus_1, valid
    );
endinterface

// File: rtl/if_unit.sv
// Instruction fetch unit: PC register, loader-writable instruction memory,
// registered fetch output with redirect squash and hazard stall.
module if_unit #(
    parameter int              ADDR_W   = 10,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic      clock,
    input  logic      reset,
    if_unit_if.slave  bus
);
    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [ADDR_W-1:0] pcf_q,   pcf_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              advance;
    logic              redirect;

    assign advance  = bus.enable & bus.PC_write & ~bus.prog_we;
    assign redirect = bus.branch_taken | bus.jump_taken;

    // Loader write port: active on prog_we regardless of run/stall/reset state.
    always_ff @(posedge clock) begin
        if (bus.prog_we) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Next-state: reset wins, loader cycles squash, advance fetches and steps the PC.
    always_comb begin
        pc_d    = pc_q;
        pcf_d   = pcf_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (reset) begin
            pc_d    = RESET_PC;
            pcf_d   = RESET_PC;
            instr_d = '0;
            valid_d = 1'b0;
        end else if (bus.prog_we) begin
            valid_d = 1'b0;
        end else if (advance) begin
            // Memory read sees the pre-write word, since writes land via NBA.
            instr_d = mem_q[pc_q];
            pcf_d   = pc_q;
            valid_d = ~redirect;
            if (bus.branch_taken) begin
                pc_d = bus.branch_address;
            end else if (bus.jump_taken) begin
                pc_d = bus.jump_address;
            end else begin
                pc_d = pc_q + ONE;
            end
        end
    end

    // Fetch-state registers.
    always_ff @(posedge clock) begin
        pc_q    <= pc_d;
        pcf_q   <= pcf_d;
        instr_q <= instr_d;
        valid_q <= valid_d;
    end

    assign bus.PC_current = pc_q;
    assign bus.PC_fetched = pcf_q;
    assign bus.instruc    = instr_q;
    assign bus.valid      = valid_q;
    assign bus.PC_plus_1  = pcf_q + ONE;
endmodule

// File: tb/tb_if_unit.sv
// Directed bench for if_unit: loader, sequential fetch, redirects, stalls,
// freeze, loader squash, reset override and PC wrap on a 4-bit instance.
module tb_if_unit;
    logic clock = 1'b0;
    logic reset;
    logic sreset;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    if_unit_if #(.ADDR_W(10), .DATA_W(32)) bus ();
    if_unit_if #(.ADDR_W(4),  .DATA_W(32)) sbus ();

    if_unit #(.ADDR_W(10), .DATA_W(32), .RESET_PC(10'd0)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    if_unit #(.ADDR_W(4), .DATA_W(32), .RESET_PC(4'd13)) dut_s (
        .clock(clock), .reset(sreset), .bus(sbus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [9:0] pc, input logic [9:0] pcf,
                           input logic [31:0] ins, input logic vld);
        chk({tag, ".pc"},    64'(bus.PC_current), 64'(pc));
        chk({tag, ".pcf"},   64'(bus.PC_fetched), 64'(pcf));
        chk({tag, ".ins"},   64'(bus.instruc),    64'(ins));
        chk({tag, ".vld"},   64'(bus.valid),      64'(vld));
        chk({tag, ".pcp1"},  64'(bus.PC_plus_1),  64'(10'(pcf + 10'd1)));
    endtask

    function automatic logic [31:0] word(input int a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    initial begin
        reset = 1'b1;
        sreset = 1'b1;
        bus.enable = 0; bus.PC_write = 0; bus.branch_taken = 0; bus.branch_address = '0;
        bus.jump_taken = 0; bus.jump_address = '0; bus.prog_we = 0; bus.prog_addr = '0;
        bus.prog_data = '0;
        sbus.enable = 0; sbus.PC_write = 0; sbus.branch_taken = 0; sbus.branch_address = '0;
        sbus.jump_taken = 0; sbus.jump_address = '0; sbus.prog_we = 0; sbus.prog_addr = '0;
        sbus.prog_data = '0;
        tick();
        chk_out("rst0", 10'd0, 10'd0, 32'd0, 1'b0);

        // Load mem[0..31] with A000_00xx
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.prog_we = 1; bus.prog_addr = 10'(a); bus.prog_data = word(a);
            tick();
        end
        bus.prog_we = 0;
        reset = 1'b1;
        tick();
        chk_out("rst1", 10'd0, 10'd0, 32'd0, 1'b0);

        // Sequential fetch of mem[0..3]
        reset = 1'b0;
        bus.enable = 1; bus.PC_write = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_out($sformatf("seq%0d", k), 10'(k), 10'(k - 1), word(k - 1), 1'b1);
        end
        tick();
        chk_out("seq5", 10'd5, 10'd4, word(4), 1'b1);

        // Branch and jump together at PC=5: branch wins, fetch squashed
        bus.branch_taken = 1; bus.branch_address = 10'd20;
        bus.jump_taken = 1;   bus.jump_address = 10'd40;
        tick();
        chk_out("bj", 10'd20, 10'd5, word(5), 1'b0);
        bus.branch_taken = 0; bus.jump_taken = 0;
        tick();
        chk_out("bj_tgt", 10'd21, 10'd20, word(20), 1'b1);

        // Jump alone
        bus.jump_taken = 1; bus.jump_address = 10'd8;
        tick();
        chk_out("jmp", 10'd8, 10'd21, word(21), 1'b0);
        bus.jump_taken = 0;
        tick();
        chk_out("jmp_tgt", 10'd9, 10'd8, word(8), 1'b1);

        // Stall 3 cycles with a branch pulsed: everything frozen, branch lost
        bus.PC_write = 0;
        for (int k = 0; k < 3; k++) begin
            bus.branch_taken = (k == 1); bus.branch_address = 10'd30;
            tick();
            chk_out($sformatf("stall%0d", k), 10'd9, 10'd8, word(8), 1'b1);
        end
        bus.branch_taken = 0; bus.PC_write = 1;
        tick();
        chk_out("resume", 10'd10, 10'd9, word(9), 1'b1);

        // enable low: freeze, jump ignored
        bus.enable = 0; bus.jump_taken = 1; bus.jump_address = 10'd3;
        tick();
        chk_out("frz", 10'd10, 10'd9, word(9), 1'b1);
        bus.enable = 1; bus.jump_taken = 0;

        // Loader write to current PC while running: squash, PC held, new word next
        bus.prog_we = 1; bus.prog_addr = 10'd10; bus.prog_data = 32'h1234_5678;
        tick();
        chk_out("ldsq", 10'd10, 10'd9, word(9), 1'b0);
        bus.prog_we = 0;
        tick();
        chk_out("ldnew", 10'd11, 10'd10, 32'h1234_5678, 1'b1);

        // Reset during freeze+stall with redirect pending
        bus.enable = 0; bus.PC_write = 0; bus.branch_taken = 1; bus.branch_address = 10'd30;
        reset = 1'b1;
        tick();
        chk_out("rstfrz", 10'd0, 10'd0, 32'd0, 1'b0);
        reset = 1'b0; bus.enable = 1; bus.PC_write = 1; bus.branch_taken = 0;
        tick();
        chk_out("post_rst", 10'd1, 10'd0, word(0), 1'b1);

        // 4-bit instance: RESET_PC=13, walk to 15 and wrap
        tick();
        chk("s_rst.pc", 64'(sbus.PC_current), 64'd13);
        chk("s_rst.vld", 64'(sbus.valid), 64'd0);
        sreset = 1'b0; sbus.enable = 1; sbus.PC_write = 1;
        tick();
        tick();
        chk("s_pc15", 64'(sbus.PC_current), 64'd15);
        tick();
        chk("s_wrap.pc",   64'(sbus.PC_current), 64'd0);
        chk("s_wrap.pcf",  64'(sbus.PC_fetched), 64'd15);
        chk("s_wrap.pcp1", 64'(sbus.PC_plus_1),  64'd0);
        chk("s_wrap.vld",  64'(sbus.valid),      64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/if_unit.md
IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, PC and instruction-memory address width (memory depth 2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  global run enable; low = freeze all fetch state.
REQ-007 PC_write  input  1  high = PC and fetch register may advance; low = stall (hazard hold).
REQ-008 branch_taken  input  1  redirect PC to branch_address.
REQ-009 branch_address  input  ADDR_W  branch target.
REQ-010 jump_taken  input  1  redirect PC to jump_address.
REQ-011 jump_address  input  ADDR_W  jump target.
REQ-012 prog_we  input  1  loader write strobe (program mode).
REQ-013 prog_addr  input  ADDR_W  loader write address.
REQ-014 prog_data  input  DATA_W  loader write data.
REQ-015 PC_current  output  ADDR_W  current PC register (address being fetched).
REQ-016 instruc  output  DATA_W  fetched instruction, registered.
REQ-017 PC_fetched  output  ADDR_W  PC of the word on instruc.
REQ-018 PC_plus_1  output  ADDR_W  PC_fetched + 1, modulo 2^ADDR_W, combinational from PC_fetched.
REQ-019 valid  output  1  instruc/PC_fetched hold a real instruction (low = bubble).

Function
REQ-020 SHALL contain a 2^ADDR_W x DATA_W single-port-write, synchronous-read instruction memory; no reset of contents.
REQ-021 Memory write SHALL occur on any edge with prog_we=1, independent of enable, PC_write and reset.
REQ-022 Read of an address written in the same cycle SHALL return the old word (read-first).
REQ-023 "Advance" cycle: enable=1, PC_write=1, prog_we=0, reset=0.
REQ-024 On advance, instruc <= mem[PC_current], PC_fetched <= PC_current, one-cycle fetch latency.
REQ-025 On advance, next PC priority: branch_taken -> branch_address; else jump_taken -> jump_address; else PC_current+1.
REQ-026 Branch and jump both high SHALL select branch_address; jump ignored.
REQ-027 PC increment SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-028 On advance, valid <= 1 unless branch_taken or jump_taken, then valid <= 0 (squash wrong-path fetch).
REQ-029 PC_write=0 with enable=1, prog_we=0: PC, instruc, PC_fetched, valid SHALL hold; redirect inputs ignored.
REQ-030 enable=0: all registers hold; redirect inputs ignored.
REQ-031 prog_we=1 (reset=0): PC holds, valid <= 0, instruc/PC_fetched hold.
REQ-032 No redirect is queued; a redirect asserted during a hold cycle is lost and must be re-presented by the driver.

Reset
REQ-033 reset=1 SHALL set PC_current=RESET_PC, PC_fetched=RESET_PC, instruc=0, valid=0 on the next edge, overriding enable, PC_write and redirects.
REQ-034 First advance after reset SHALL fetch mem[RESET_PC] with valid=1 one cycle later.
REQ-035 Reset mid-stall or mid-redirect SHALL discard the pending state; no side effect except REQ-021 writes.

Verification
REQ-036 Load mem[0..3]=A0,A1,A2,A3 via prog_we, reset, then advance 4 cycles -> instruc A0..A3 on cycles 1..4, PC_fetched 0..3, valid=1, PC_plus_1 1..4.
REQ-037 Advance with PC_current=5, branch_taken=1, branch_address=20, jump_taken=1, jump_address=40 -> next PC_current=20, valid=0 next cycle, then instruc=mem[20] valid=1.
REQ-038 PC_write=0 for 3 cycles mid-stream with branch_taken pulsed -> all outputs frozen, PC unchanged, branch ignored; resumes at PC+1.
REQ-039 ADDR_W=4, PC_current=15, advance -> PC_current=0, PC_fetched=15, PC_plus_1=0.
REQ-040 prog_we to address equal to PC_current while enable=1 -> valid=0, PC held; next advance returns new word.
REQ-041 reset asserted during enable=0 and PC_write=0 -> PC_current=RESET_PC, valid=0, instruc=0 after one edge.
